// File: rtl/life_cell_gen.sv
// ---------------------------------------------------------------------------
// life_cell_gen
//   One cell of a cellular-automaton grid. Supports any life-like Bx/Sy rule
//   (runtime-writable masks), multi-state "Generations" decay when
//   N_STATES > 2, a saturating alive-age counter and a change flag.
//
// Parameters
//   S_0      reset state value (< N_STATES)
//   N_STATES number of cell states (2 = alive/dead, >2 adds decay states)
//   STATE_W  width of the state register (2**STATE_W >= N_STATES)
//   AGE_W    width of the saturating alive-age counter
//   BIRTH    reset birth mask   (bit k = birth with k live neighbours)
//   SURVIVE  reset survive mask (bit k = survival with k live neighbours)
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active-high
//   step         advance one generation on this edge
//   nbr          neighbour status bits {Tl,T,Tr,L,R,Bl,B,Br}
//   load         force state from load_state (overrides step)
//   load_state   value written on load (illegal values load as 0)
//   rule_wr      write both rule masks
//   rule_birth   new birth mask
//   rule_survive new survive mask
//   status       1 iff state == 1; feeds the neighbouring cells
//   state        full cell state
//   age          generations spent alive, saturating
//   changed      state changed on the last step/load
//   osc2         (LIFE_CELL_HISTORY_EN only) new state equals the state two
//                steps earlier: still life or period-2 oscillator
//
// Optional feature macro: LIFE_CELL_HISTORY_EN
// ---------------------------------------------------------------------------
module life_cell_gen #(
   parameter int         S_0      = 0,
   parameter int         N_STATES = 2,
   parameter int         STATE_W  = 4,
   parameter int         AGE_W    = 8,
   parameter logic [8:0] BIRTH    = 9'h008,
   parameter logic [8:0] SURVIVE  = 9'h00C
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               step,
   input  logic [7:0]         nbr,
   input  logic               load,
   input  logic [STATE_W-1:0] load_state,
   input  logic               rule_wr,
   input  logic [8:0]         rule_birth,
   input  logic [8:0]         rule_survive,
   output logic               status,
   output logic [STATE_W-1:0] state,
   output logic [AGE_W-1:0]   age,
   output logic               changed
`ifdef LIFE_CELL_HISTORY_EN
   ,
   output logic               osc2
`endif
);

   localparam logic [STATE_W-1:0] ST_DEAD   = '0;
   localparam logic [STATE_W-1:0] ST_ALIVE  = STATE_W'(1);
   localparam logic [STATE_W-1:0] ST_DECAY0 = STATE_W'(2);
   localparam logic [STATE_W-1:0] ST_INIT   = STATE_W'(S_0);
   // One extra bit so N_STATES == 2**STATE_W is still representable.
   localparam logic [STATE_W:0]   N_LIM     = (STATE_W+1)'(N_STATES);
   localparam logic [AGE_W-1:0]   AGE_MAX   = '1;

   typedef enum logic [1:0] {
      CL_DEAD,
      CL_ALIVE,
      CL_DECAY,
      CL_ILLEGAL
   } cell_class_t;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) begin
         c = c + {3'b000, v[i]};
      end
      return c;
   endfunction

   function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
      return (a == AGE_MAX) ? a : a + AGE_W'(1);
   endfunction

   function automatic logic [STATE_W-1:0] legalise(input logic [STATE_W-1:0] s);
      return ({1'b0, s} >= N_LIM) ? ST_DEAD : s;
   endfunction

   logic [8:0]         birth_mask;
   logic [8:0]         survive_mask;
   logic [3:0]         cnt;
   cell_class_t        cls;
   logic [STATE_W:0]   state_inc;
   logic [STATE_W-1:0] nxt_state;
   logic [AGE_W-1:0]   nxt_age;
   logic [STATE_W-1:0] ld_val;

   // Next-state decode: classify the current state, then apply the rule.
   always_comb begin
      cnt       = popcount8(nbr);
      state_inc = {1'b0, state} + (STATE_W+1)'(1);
      ld_val    = legalise(load_state);
      cls       = CL_ILLEGAL;
      nxt_state = ST_DEAD;

      if (state == ST_DEAD) begin
         cls = CL_DEAD;
      end else if (state == ST_ALIVE) begin
         cls = CL_ALIVE;
      end else if ({1'b0, state} < N_LIM) begin
         cls = CL_DECAY;
      end

      unique case (cls)
         CL_DEAD:  nxt_state = birth_mask[cnt] ? ST_ALIVE : ST_DEAD;
         CL_ALIVE: begin
            if (survive_mask[cnt]) begin
               nxt_state = ST_ALIVE;
            end else if (N_STATES > 2) begin
               nxt_state = ST_DECAY0;
            end else begin
               nxt_state = ST_DEAD;
            end
         end
         // Decay states ignore neighbours and count up to the wrap into dead.
         CL_DECAY: nxt_state = (state_inc < N_LIM) ? state_inc[STATE_W-1:0] : ST_DEAD;
         default:  nxt_state = ST_DEAD;
      endcase

      nxt_age = ((state == ST_ALIVE) && (nxt_state == ST_ALIVE)) ? age_sat_inc(age) : '0;
   end

   // State register: rst > load > step; rule_wr is independent of load/step.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_INIT;
         status       <= (ST_INIT == ST_ALIVE);
         age          <= '0;
         changed      <= 1'b0;
         birth_mask   <= BIRTH;
         survive_mask <= SURVIVE;
      end else begin
         // A step on this edge still decodes with the old masks.
         if (rule_wr) begin
            birth_mask   <= rule_birth;
            survive_mask <= rule_survive;
         end
         if (load) begin
            state   <= ld_val;
            status  <= (ld_val == ST_ALIVE);
            age     <= '0;
            changed <= (load_state != state);
         end else if (step) begin
            state   <= nxt_state;
            status  <= (nxt_state == ST_ALIVE);
            age     <= nxt_age;
            changed <= (nxt_state != state);
         end else begin
            changed <= 1'b0;
         end
      end
   end

`ifdef LIFE_CELL_HISTORY_EN
   logic [STATE_W-1:0] hist_a;    // state before the last step
   logic [STATE_W-1:0] hist_b;    // state before the step before that
   logic [1:0]         hist_vld;  // steps seen since rst/load, saturating at 2

   // History register: the new state is compared with the state held before
   // the previous step, i.e. two generations back.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         hist_a   <= '0;
         hist_b   <= '0;
         hist_vld <= 2'd0;
         osc2     <= 1'b0;
      end else if (step) begin
         osc2     <= (hist_vld == 2'd2) && (nxt_state == hist_a);
         hist_a   <= state;
         hist_b   <= hist_a;
         hist_vld <= (hist_vld == 2'd2) ? 2'd2 : hist_vld + 2'd1;
      end
   end
`endif

endmodule

// File: tb/tb_life_cell_gen.sv
// ---------------------------------------------------------------------------
// tb_life_cell_gen
//   Two cell instances driven by the same stimulus: a classic two-state cell
//   (AGE_W=8) and a three-state Generations cell with a 2-bit age counter.
//   A behavioural model recomputes each cell from the Life rules every edge.
// ---------------------------------------------------------------------------
module tb_life_cell_gen;

   localparam int SW = 4;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, step, load, rule_wr;
   logic [7:0]    nbr;
   logic [SW-1:0] load_state;
   logic [8:0]    rule_birth, rule_survive;

   logic          status_a, status_b, changed_a, changed_b;
   logic [SW-1:0] state_a, state_b;
   logic [7:0]    age_a;
   logic [1:0]    age_b;
`ifdef LIFE_CELL_HISTORY_EN
   logic          osc2_a, osc2_b;
`endif

   life_cell_gen #(.N_STATES(2), .STATE_W(SW), .AGE_W(8)) dut_a (
      .clk(clk), .rst(rst), .step(step), .nbr(nbr), .load(load),
      .load_state(load_state), .rule_wr(rule_wr), .rule_birth(rule_birth),
      .rule_survive(rule_survive), .status(status_a), .state(state_a),
      .age(age_a), .changed(changed_a)
`ifdef LIFE_CELL_HISTORY_EN
      , .osc2(osc2_a)
`endif
   );

   life_cell_gen #(.N_STATES(3), .STATE_W(SW), .AGE_W(2)) dut_b (
      .clk(clk), .rst(rst), .step(step), .nbr(nbr), .load(load),
      .load_state(load_state), .rule_wr(rule_wr), .rule_birth(rule_birth),
      .rule_survive(rule_survive), .status(status_b), .state(state_b),
      .age(age_b), .changed(changed_b)
`ifdef LIFE_CELL_HISTORY_EN
      , .osc2(osc2_b)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         ms[2];
   int         ma[2];
   int         mc[2];
   int         mh[2];
   int         mv_cnt[2];
   int         mo[2];
   logic [8:0] mb, mv;

   function automatic int rule_next(input int st, input int cnt, input int n);
      if (st == 0)          return mb[cnt] ? 1 : 0;
      else if (st == 1)     return mv[cnt] ? 1 : ((n == 2) ? 0 : 2);
      else if (st < n)      return (st + 1 < n) ? st + 1 : 0;
      else                  return 0;
   endfunction

   task automatic model_edge();
      int n, amax, nv, ls;
      for (int i = 0; i < 2; i++) begin
         n    = (i == 0) ? 2 : 3;
         amax = (i == 0) ? 255 : 3;
         ls   = int'(load_state);
         if (rst) begin
            ms[i] = 0; ma[i] = 0; mc[i] = 0;
            mh[i] = 0; mv_cnt[i] = 0; mo[i] = 0;
         end else if (load) begin
            nv    = (ls >= n) ? 0 : ls;
            mc[i] = (ls != ms[i]) ? 1 : 0;
            ms[i] = nv;
            ma[i] = 0;
            mh[i] = 0; mv_cnt[i] = 0; mo[i] = 0;
         end else if (step) begin
            nv    = rule_next(ms[i], $countones(nbr), n);
            ma[i] = (ms[i] == 1 && nv == 1) ? ((ma[i] + 1 > amax) ? amax : ma[i] + 1) : 0;
            mc[i] = (nv != ms[i]) ? 1 : 0;
            mo[i] = (mv_cnt[i] == 2 && nv == mh[i]) ? 1 : 0;
            mh[i] = ms[i];
            if (mv_cnt[i] < 2) mv_cnt[i]++;
            ms[i] = nv;
         end else begin
            mc[i] = 0;
         end
      end
      if (rst) begin
         mb = 9'h008; mv = 9'h00C;
      end else if (rule_wr) begin
         mb = rule_birth; mv = rule_survive;
      end
   endtask

   task automatic compare_all();
      check("state_a",   state_a,   ms[0]);
      check("status_a",  status_a,  (ms[0] == 1));
      check("age_a",     age_a,     ma[0]);
      check("changed_a", changed_a, mc[0]);
      check("state_b",   state_b,   ms[1]);
      check("status_b",  status_b,  (ms[1] == 1));
      check("age_b",     age_b,     ma[1]);
      check("changed_b", changed_b, mc[1]);
`ifdef LIFE_CELL_HISTORY_EN
      check("osc2_a",    osc2_a,    mo[0]);
      check("osc2_b",    osc2_b,    mo[1]);
`endif
   endtask

   // One clock: drive, let the edge happen, update the model, sample #1 later.
   task automatic cycle(input logic r, input logic s, input logic [7:0] nb,
                        input logic ld, input logic [SW-1:0] ls,
                        input logic rw, input logic [8:0] rb, input logic [8:0] rs);
      rst = r; step = s; nbr = nb; load = ld; load_state = ls;
      rule_wr = rw; rule_birth = rb; rule_survive = rs;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic do_step(input logic [7:0] nb);
      cycle(1'b0, 1'b1, nb, 1'b0, '0, 1'b0, 9'h0, 9'h0);
   endtask

   task automatic do_load(input logic [SW-1:0] ls);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, ls, 1'b0, 9'h0, 9'h0);
   endtask

   int exp_age_b[5] = '{0, 1, 2, 3, 3};
`ifdef LIFE_CELL_HISTORY_EN
   int exp_osc[4] = '{0, 0, 1, 1};
`endif

   initial begin
      rst = 1'b1; step = 1'b0; load = 1'b0; rule_wr = 1'b0;
      nbr = '0; load_state = '0; rule_birth = '0; rule_survive = '0;
      mb = 9'h008; mv = 9'h00C;

      // Reset
      cycle(1'b1, 1'b0, 8'h00, 1'b0, '0, 1'b0, 9'h0, 9'h0);
      cycle(1'b1, 1'b0, 8'h00, 1'b0, '0, 1'b0, 9'h0, 9'h0);
      check("rst_state",   state_a,   0);
      check("rst_status",  status_a,  0);
      check("rst_age",     age_a,     0);
      check("rst_changed", changed_a, 0);
      do_step(8'hFF);
      check("dead_ff_state",   state_a,   0);
      check("dead_ff_changed", changed_a, 0);

      // Default B3/S23
      do_step(8'b0000_0111);
      check("birth_status",  status_a,  1);
      check("birth_changed", changed_a, 1);
      check("birth_age",     age_a,     0);
      do_step(8'b0000_0011);
      check("survive_status",  status_a,  1);
      check("survive_age",     age_a,     1);
      check("survive_changed", changed_a, 0);
      do_step(8'hFF);
      check("overcrowd_status",  status_a,  0);
      check("overcrowd_age",     age_a,     0);
      check("overcrowd_changed", changed_a, 1);

      // Generations decay on the three-state cell
      do_load(4'd1);
      do_step(8'h00);
      check("gen_decay_state",  state_b,  2);
      check("gen_decay_status", status_b, 0);
      do_step(8'b0000_0111);
      check("gen_no_birth", state_b, 0);
      do_step(8'b0000_0111);
      check("gen_rebirth", state_b, 1);

      // Rule write on the same edge as step uses the old masks
      do_load(4'd0);
      cycle(1'b0, 1'b1, 8'b0000_0011, 1'b0, '0, 1'b1, 9'h004, 9'h00C);
      check("race_old_rule", state_a, 0);
      do_step(8'b0000_0011);
      check("race_new_rule", state_a, 1);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, '0, 1'b1, 9'h008, 9'h00C);
      check("idle_changed", changed_a, 0);

      // Age saturation on the 2-bit counter, then load over step
      do_load(4'd0);
      do_step(8'b0000_0111);
      check("sat_age_0", age_b, exp_age_b[0]);
      for (int k = 1; k < 5; k++) begin
         do_step(8'b0000_0011);
         check($sformatf("sat_age_%0d", k), age_b, exp_age_b[k]);
      end
      cycle(1'b0, 1'b1, 8'b0000_0011, 1'b1, 4'd0, 1'b0, 9'h0, 9'h0);
      check("load_prio_state",   state_b,   0);
      check("load_prio_age",     age_b,     0);
      check("load_prio_changed", changed_b, 1);
      do_load(4'd5);
      check("load_illegal_a", state_a, 0);
      check("load_illegal_b", state_b, 0);

      // Reset discards a concurrent step, load and rule write
      cycle(1'b1, 1'b1, 8'b0000_0111, 1'b1, 4'd1, 1'b1, 9'h000, 9'h000);
      check("rst_mid_state", state_a, 0);
      do_step(8'b0000_0111);
      check("rst_mid_rule_kept", status_a, 1);

`ifdef LIFE_CELL_HISTORY_EN
      // Blinker-like drive: 1 -> 0 -> 1 -> 0 -> 1
      do_load(4'd1);
      for (int k = 0; k < 4; k++) begin
         do_step((k % 2 == 0) ? 8'hFF : 8'b0000_0111);
         check($sformatf("osc2_blink_%0d", k), osc2_a, exp_osc[k]);
      end
      cycle(1'b1, 1'b0, 8'h00, 1'b0, '0, 1'b0, 9'h0, 9'h0);
      check("osc2_rst", osc2_a, 0);
`endif

      // Randomised traffic
      for (int k = 0; k < 600; k++) begin
         logic r, s, ld, rw;
         r  = ($urandom_range(0, 99) < 2);
         s  = ($urandom_range(0, 99) < 70);
         ld = ($urandom_range(0, 99) < 8);
         rw = ($urandom_range(0, 99) < 5);
         cycle(r, s, 8'($urandom), ld, SW'($urandom), rw, 9'($urandom), 9'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/life_cell_gen.md
Name: life_cell_gen

Overview:
- Parametrised successor to the single-bit Life cell: one cell of the grid array, driven by its 8 neighbours' status bits.
- Supports any life-like rule (Bx/Sy masks, runtime-writable).
- Supports multi-state "Generations" decay (N_STATES > 2).
- Provides an alive-age counter and a change flag for the display/statistics logic.

Parameters:
- S_0, 0: reset/initial state value; must be < N_STATES.
- N_STATES, 2: number of cell states. 2 = classic alive/dead; >2 adds refractory decay states 2..N_STATES-1.
- STATE_W, 4: width of state register; must satisfy 2^STATE_W >= N_STATES.
- AGE_W, 8: width of saturating alive-age counter.
- BIRTH, 9'h008: reset birth mask; bit k set = birth with k live neighbours (B3).
- SURVIVE, 9'h00C: reset survive mask; bit k set = survival with k live neighbours (S23).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- step  in  1  advance one generation on this edge.
- nbr  in  8  neighbour status bits {Tl,T,Tr,L,R,Bl,B,Br}.
- load  in  1  force state from load_state.
- load_state  in  STATE_W  value written on load.
- rule_wr  in  1  write rule masks.
- rule_birth  in  9  new birth mask.
- rule_survive  in  9  new survive mask.
- status  out  1  1 iff state == 1 (alive); feeds neighbours.
- state  out  STATE_W  full cell state.
- age  out  AGE_W  generations alive, saturating.
- changed  out  1  state changed on last step/load.

Behaviour:
- Reset values: state = S_0; status = (S_0 == 1); age = 0; changed = 0; birth mask = BIRTH; survive mask = SURVIVE.
- All outputs are registered. Latency from step edge to new state/status/age/changed is 1 cycle. nbr is sampled on the same edge as step.
- cnt = popcount(nbr), range 0..8, 4-bit.
- Priority: rst > load > step. When no control is asserted, all state holds and changed is cleared to 0.
- Next-state on step (FSM per state value):
  - DEAD (0): go to 1 if birth_mask[cnt], else stay 0.
  - ALIVE (1): stay 1 if survive_mask[cnt]. Else go to 0 when N_STATES == 2, or to 2 when N_STATES > 2.
  - DECAY (k >= 2): go to k+1 if k+1 < N_STATES, else 0. Neighbours are ignored; no birth is possible in a decay state.
  - Illegal state (>= N_STATES): go to 0.
- age:
  - Cleared to 0 on every step whose resulting state is not 1.
  - Cleared to 0 on a transition into 1.
  - Incremented on a step where the cell is 1 before and after, saturating at 2^AGE_W-1 (no wrap).
- changed: on step, 1 iff next state != current state. On load, 1 iff load_state differs from state. Cleared on rst and on any cycle without step or load.
- load:
  - state <= load_state. If load_state >= N_STATES, state <= 0.
  - age <= 0.
  - A concurrent step is ignored.
- Rule masks:
  - rule_wr updates both masks on the edge.
  - A step on the same edge as rule_wr uses the old masks; the new masks apply from the next step.
  - rule_wr is independent of load/step priority; rst overrides it.
- Reset asserted mid-sequence discards any pending step/load/rule_wr on that edge.

Optional Feature:
- Macro: LIFE_CELL_HISTORY_EN.
- When defined:
  - Adds output port osc2 (1 bit).
  - Adds two history registers holding the state before the last two steps.
  - osc2 is registered and updates only on step: 1 when the new state equals the state two steps earlier (still life or period-2 oscillator).
  - Valid only after 2 steps since rst/load: a valid counter (0..2) gates osc2 to 0 before then.
  - rst and load clear the history and set osc2 to 0.
- When undefined: no osc2 port, no history registers; all other behaviour identical.

Test Plan:
- Reset, S_0=0: after rst, status=0, state=0, age=0, changed=0. Then step with nbr=8'hFF → state stays 0, changed=0.
- Birth/survive, default rule: state 0, nbr=8'b00000111, step → next cycle status=1, changed=1, age=0. Step with nbr=8'b00000011 → status=1, age=1, changed=0. Step with nbr=8'hFF → status=0, age=0, changed=1.
- Generations, N_STATES=3: load_state=1, then step with nbr=0 → state=2, status=0. Step with nbr=8'b00000111 → state=0 (no birth). Step with same nbr → state=1.
- Rule write race: rule_wr with birth=9'h004 on the same edge as step with cnt=2 from state 0 → stays 0. Next step with cnt=2 → state=1.
- Age saturation/priority, AGE_W=2: alive with nbr=8'b00000011 for 5 steps → age 0,1,2,3,3. Then load=1 with load_state=0 and step=1 on the same edge → state=0, age=0, changed=1. load_state=5 with N_STATES=2 → state=0.
- LIFE_CELL_HISTORY_EN: blinker-like drive alternating 1/0 states → osc2=0 for first 2 steps, then 1. Assert rst mid-run → osc2=0 next cycle.
